// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared state encoding and size derivations for the
//                multi-cycle multiply-accumulate sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_pkg;

    // Sequencer states: operand capture, per-chunk accumulate, result hold
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int STEP_BITS_DEF = 8;

    // Number of multiplier chunks in a full 32-bit rs
    function automatic int mul_nstep(input int step_bits);
        return 32 / step_bits;
    endfunction

    // Width needed to hold a step count of 1..NSTEP
    function automatic int mul_cnt_w(input int step_bits);
        return $clog2(32 / step_bits) + 1;
    endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_step_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_step_unit
//  Description : Combinational single-step datapath: adds one shifted
//                partial product (rm_ext * chunk) into a 64-bit accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_step_unit #(
    parameter int STEP_BITS = 8
) (
    input  logic [63:0]          acc_i,
    input  logic [63:0]          rm_ext_i,
    input  logic [STEP_BITS-1:0] chunk_i,
    input  logic                 chunk_signed_i,
    input  logic [5:0]           shift_i,
    output logic [63:0]          sum_o
);

    logic [63:0] w_chunk_ext;
    logic [63:0] w_prod;

    // Extend the chunk to 64 bits; the product is only needed modulo 2^64
    always_comb begin
        if (chunk_signed_i) begin
            w_chunk_ext = {{(64-STEP_BITS){chunk_i[STEP_BITS-1]}}, chunk_i};
        end else begin
            w_chunk_ext = {{(64-STEP_BITS){1'b0}}, chunk_i};
        end
        w_prod = rm_ext_i * w_chunk_ext;
        sum_o  = acc_i + (w_prod << shift_i);
    end

endmodule : mul_step_unit
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sequencer
//  Description : Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL sequencer with
//                ARM7-style early termination on the multiplier operand.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int STEP_BITS = STEP_BITS_DEF,
    parameter int CNT_W     = mul_cnt_w(STEP_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_long,
    input  logic             req_signed,
    input  logic             req_acc,
    input  logic [31:0]      req_rm,
    input  logic [31:0]      req_rs,
    input  logic [31:0]      req_acc_hi,
    input  logic [31:0]      req_acc_lo,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_hi,
    output logic [31:0]      resp_lo,
    output logic             resp_n,
    output logic             resp_z,
    output logic [CNT_W-1:0] resp_steps
);

    localparam int NSTEP = mul_nstep(STEP_BITS);

    mul_state_t        state_q;
    logic [CNT_W-1:0]  k_q;
    logic [31:0]       rm_q;
    logic [31:0]       rs_q;
    logic              long_q;
    logic              signed_q;
    logic [63:0]       acc_q;
    logic [63:0]       acc_d;
    logic              resp_valid_q;
    logic [31:0]       resp_hi_q;
    logic [31:0]       resp_lo_q;
    logic              resp_n_q;
    logic              resp_z_q;
    logic [CNT_W-1:0]  resp_steps_q;

    logic [63:0]          w_rm_ext;
    logic                 w_sgn;
    logic [31:0]          w_shift;
    logic [31:0]          w_top_shift;
    logic [STEP_BITS-1:0] w_chunk;
    logic [31:0]          w_top_s;
    logic [31:0]          w_top_u;
    logic                 w_last;
    logic                 w_term;

    // Current chunk, bits above it, and the early-termination decision
    always_comb begin
        w_sgn       = !long_q || signed_q;
        w_rm_ext    = (long_q && signed_q) ? {{32{rm_q[31]}}, rm_q} : {32'd0, rm_q};
        w_shift     = 32'(k_q) * 32'(STEP_BITS);
        w_top_shift = w_shift + 32'(STEP_BITS);
        w_chunk     = STEP_BITS'(rs_q >> w_shift);
        w_top_s     = 32'($signed(rs_q) >>> w_top_shift);
        w_top_u     = rs_q >> w_top_shift;
        w_last      = (k_q == CNT_W'(NSTEP - 1));
        if (w_sgn) begin
            w_term = w_last || (w_top_s == {32{w_chunk[STEP_BITS-1]}});
        end else begin
            w_term = w_last || (w_top_u == 32'd0);
        end
    end

    mul_step_unit #(
        .STEP_BITS(STEP_BITS)
    ) u_step (
        .acc_i          (acc_q),
        .rm_ext_i       (w_rm_ext),
        .chunk_i        (w_chunk),
        .chunk_signed_i (w_term && w_sgn),
        .shift_i        (w_shift[5:0]),
        .sum_o          (acc_d)
    );

    // FSM, operand capture, accumulation and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            rm_q         <= '0;
            rs_q         <= '0;
            long_q       <= 1'b0;
            signed_q     <= 1'b0;
            acc_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hi_q    <= '0;
            resp_lo_q    <= '0;
            resp_n_q     <= 1'b0;
            resp_z_q     <= 1'b0;
            resp_steps_q <= '0;
        end else if (flush) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        rm_q     <= req_rm;
                        rs_q     <= req_rs;
                        long_q   <= req_long;
                        signed_q <= req_long && req_signed;
                        if (!req_acc) begin
                            acc_q <= '0;
                        end else if (req_long) begin
                            acc_q <= {req_acc_hi, req_acc_lo};
                        end else begin
                            acc_q <= {32'd0, req_acc_lo};
                        end
                        k_q     <= '0;
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    acc_q <= acc_d;
                    if (w_term) begin
                        resp_steps_q <= k_q + CNT_W'(1);
                        state_q      <= ST_DONE;
                    end else begin
                        k_q <= k_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // First DONE cycle loads the result; it then holds until accepted
                    if (!resp_valid_q) begin
                        resp_hi_q    <= long_q ? acc_q[63:32] : 32'd0;
                        resp_lo_q    <= acc_q[31:0];
                        resp_n_q     <= long_q ? acc_q[63] : acc_q[31];
                        resp_z_q     <= long_q ? (acc_q == 64'd0) : (acc_q[31:0] == 32'd0);
                        resp_valid_q <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_hi    = resp_hi_q;
    assign resp_lo    = resp_lo_q;
    assign resp_n     = resp_n_q;
    assign resp_z     = resp_z_q;
    assign resp_steps = resp_steps_q;

endmodule : mul_sequencer
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_sequencer
//  Description : Directed self-checking bench for mul_sequencer
//                (STEP_BITS = 8, four steps maximum).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_long = 1'b0;
    logic             req_signed = 1'b0;
    logic             req_acc = 1'b0;
    logic [31:0]      req_rm = '0;
    logic [31:0]      req_rs = '0;
    logic [31:0]      req_acc_hi = '0;
    logic [31:0]      req_acc_lo = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_hi;
    logic [31:0]      resp_lo;
    logic             resp_n;
    logic             resp_z;
    logic [CNT_W-1:0] resp_steps;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.STEP_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_long   (req_long),
        .req_signed (req_signed),
        .req_acc    (req_acc),
        .req_rm     (req_rm),
        .req_rs     (req_rs),
        .req_acc_hi (req_acc_hi),
        .req_acc_lo (req_acc_lo),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .resp_n     (resp_n),
        .resp_z     (resp_z),
        .resp_steps (resp_steps)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one request at a falling edge; returns after the accepting edge
    task automatic start_op(input string tag, input logic lng, input logic sgn, input logic acc,
                            input logic [31:0] rm, input logic [31:0] rs,
                            input logic [31:0] ahi, input logic [31:0] alo);
        @(negedge clk);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_long   = lng;
        req_signed = sgn;
        req_acc    = acc;
        req_rm     = rm;
        req_rs     = rs;
        req_acc_hi = ahi;
        req_acc_lo = alo;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // Count edges after acceptance until resp_valid, bounded
    task automatic wait_resp(input string tag, output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
    endtask

    task automatic release_resp(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
        check({tag, "_idle"}, 64'(req_ready), 64'd1);
    endtask

    task automatic do_op(input string tag, input logic lng, input logic sgn, input logic acc,
                         input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] ahi, input logic [31:0] alo,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic en, input logic ez, input int esteps);
        int lat;
        start_op(tag, lng, sgn, acc, rm, rs, ahi, alo);
        wait_resp(tag, lat);
        check({tag, "_hi"}, 64'(resp_hi), 64'(ehi));
        check({tag, "_lo"}, 64'(resp_lo), 64'(elo));
        check({tag, "_n"}, 64'(resp_n), 64'(en));
        check({tag, "_z"}, 64'(resp_z), 64'(ez));
        check({tag, "_steps"}, 64'(resp_steps), 64'(esteps));
        check({tag, "_latency"}, 64'(lat), 64'(esteps + 1));
        release_resp(tag);
    endtask

    // Start UMULL 0x12345678*0x9ABCDEF0 and return while step k=2 is active
    task automatic start_abort_op(input string tag);
        start_op(tag, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 64'(req_ready), 64'd0);
    endtask

    task automatic watch_no_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check({tag, "_no_valid"}, 64'(seen), 64'd0);
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int lat;

        // Reset state
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_lo", 64'(resp_lo), 64'd0);
        check("rst_resp_steps", 64'(resp_steps), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        //    tag        lng   sgn   acc   rm             rs             acc_hi  acc_lo         hi             lo             N     Z     steps
        do_op("mul",     1'b0, 1'b0, 1'b0, 32'd3,         32'd5,         32'd0,  32'd0,         32'd0,         32'd15,        1'b0, 1'b0, 1);
        do_op("umull",   1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'd0,         32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 4);
        do_op("smull",   1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0,  32'd0,         32'd0,         32'd6,         1'b0, 1'b0, 1);
        do_op("umlal",   1'b1, 1'b0, 1'b1, 32'd2,         32'd3,         32'd0,  32'hFFFF_FFFF, 32'd1,         32'd5,         1'b0, 1'b0, 1);
        do_op("mla_z",   1'b0, 1'b0, 1'b1, 32'd0,         32'd7,         32'd0,  32'd0,         32'd0,         32'd0,         1'b0, 1'b1, 1);
        do_op("mul_neg", 1'b0, 1'b0, 1'b0, 32'd7,         32'hFFFF_FFFF, 32'd0,  32'd0,         32'd0,         32'hFFFF_FFF9, 1'b1, 1'b0, 1);
        do_op("mul_2st", 1'b0, 1'b0, 1'b0, 32'd1,         32'h0000_0100, 32'd0,  32'd0,         32'd0,         32'h0000_0100, 1'b0, 1'b0, 2);
        do_op("smlal",   1'b1, 1'b1, 1'b1, 32'd5,         32'hFFFF_FFFF, 32'd0,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0, 1);

        // Backpressure: result held stable while resp_ready is low
        start_op("hold", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_resp("hold", lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_valid_%0d", i), 64'(resp_valid), 64'd1);
            check($sformatf("hold_ready_%0d", i), 64'(req_ready), 64'd0);
            check($sformatf("hold_res_%0d", i), {resp_hi, resp_lo}, 64'hFFFF_FFFE_0000_0001);
        end
        release_resp("hold");

        // A request presented together with flush is not accepted
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_req_rejected", 64'(req_ready), 64'd1);

        // Flush at step 2 aborts the operation
        start_abort_op("flush");
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_resp_valid", 64'(resp_valid), 64'd0);
        watch_no_valid("flush");
        do_op("flush_mul", 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd15, 1'b0, 1'b0, 1);

        // Asynchronous reset at step 2 clears everything immediately
        start_abort_op("arst");
        reset = 1'b1;
        #1;
        check("arst_ready", 64'(req_ready), 64'd1);
        check("arst_lo", 64'(resp_lo), 64'd0);
        check("arst_steps", 64'(resp_steps), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        watch_no_valid("arst");
        do_op("arst_mul", 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd15, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mul_sequencer
`default_nettype wire
